// File: rtl/algo_4ror1w_trf_gen.sv
// Fill-then-verify traffic generator for a 1-write / 4-read memory with a fixed read latency.
// Optional refresh insertion is enabled by defining ALGO_4ROR1W_TRF_REFR_EN.
module algo_4ror1w_trf_gen #(
  parameter int WIDTH = 64,
  parameter int BITADDR = 13,
  parameter int NUMADDR = 8192,
  parameter int DELAY = 2,
  parameter logic [WIDTH-1:0] SEED = '0,
  parameter int REFFREQ = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ready,
  input  logic                 start,
  output logic                 write,
  output logic [BITADDR-1:0]   wr_adr,
  output logic [WIDTH-1:0]     din,
  output logic [3:0]           read,
  output logic [4*BITADDR-1:0] rd_adr,
  output logic                 refr,
  input  logic [3:0]           rd_vld,
  input  logic [4*WIDTH-1:0]   rd_dout,
  input  logic [3:0]           rd_serr,
  input  logic [3:0]           rd_derr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          err_cnt
);

  localparam int CW  = BITADDR + 2;
  localparam int DCW = $clog2(DELAY + 1);

  if (DELAY < 1 || REFFREQ < 2) begin : g_bad_param
    $error("algo_4ror1w_trf_gen: DELAY must be >= 1 and REFFREQ >= 2");
  end

  typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DCW-1:0]  dcnt, dcnt_nxt;
  logic            issue;
  logic            refr_now;
  logic [2:0]      nerr;
  logic [15:0]     err_cnt_nxt;
  logic [3:0]      pvld [DELAY];
  logic [4*WIDTH-1:0] pdat [DELAY];

  // Single-bit errors are corrected by the memory, so they never count.
  logic unused_serr;
  assign unused_serr = ^rd_serr;

  function automatic logic [BITADDR-1:0] wrap_adr(input logic [CW-1:0] a);
    logic [CW-1:0] w;
    w = (a >= CW'(NUMADDR)) ? a - CW'(NUMADDR) : a;
    return w[BITADDR-1:0];
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

`ifdef ALGO_4ROR1W_TRF_REFR_EN
  localparam int RW = $clog2(REFFREQ);
  logic [RW-1:0] rcnt;

  assign refr_now = ready && (rcnt == RW'(REFFREQ - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      rcnt <= '0;
      refr <= 1'b0;
    end else begin
      refr <= refr_now;
      if (refr_now)
        rcnt <= '0;
      else if (ready)
        rcnt <= rcnt + 1'b1;
    end
  end
`else
  assign refr_now = 1'b0;
  assign refr     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dcnt_nxt  = dcnt;
    issue     = (state == FILL || state == READ) && ready && !refr_now;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
      end
      FILL: begin
        if (issue) begin
          if (cnt == CW'(NUMADDR - 1)) begin
            state_nxt = READ;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          cnt_nxt = cnt + CW'(4);
          if (cnt + CW'(4) >= CW'(NUMADDR)) begin
            state_nxt = DRAIN;
            dcnt_nxt  = '0;
          end
        end
      end
      DRAIN: begin
        if (dcnt == DCW'(DELAY - 1))
          state_nxt = DONE;
        else
          dcnt_nxt = dcnt + 1'b1;
      end
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // command stage: control and registered memory command
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dcnt   <= '0;
      write  <= 1'b0;
      read   <= 4'b0;
      wr_adr <= '0;
      din    <= '0;
      rd_adr <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dcnt  <= dcnt_nxt;
      write <= issue && (state == FILL);
      read  <= {4{issue && (state == READ)}};
      if (issue && state == FILL) begin
        wr_adr <= cnt[BITADDR-1:0];
        din    <= WIDTH'(cnt[BITADDR-1:0]) ^ SEED;
      end
      if (issue && state == READ) begin
        for (int p = 0; p < 4; p++)
          rd_adr[p*BITADDR +: BITADDR] <= wrap_adr(cnt + CW'(p));
      end
      busy <= (state_nxt == FILL) || (state_nxt == READ) || (state_nxt == DRAIN);
      done <= (state_nxt == DONE);
    end
  end

  // expectation pipe: fed from the issued read command, so its head lines up with rd_vld
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DELAY; i++) begin
        pvld[i] <= 4'b0;
        pdat[i] <= '0;
      end
    end else begin
      pvld[0] <= read;
      for (int p = 0; p < 4; p++)
        pdat[0][p*WIDTH +: WIDTH] <= WIDTH'(rd_adr[p*BITADDR +: BITADDR]) ^ SEED;
      for (int i = 1; i < DELAY; i++) begin
        pvld[i] <= pvld[i-1];
        pdat[i] <= pdat[i-1];
      end
    end
  end

  always_comb begin
    nerr = 3'd0;
    for (int p = 0; p < 4; p++) begin
      if (pvld[DELAY-1][p]) begin
        if (!rd_vld[p] || rd_derr[p] ||
            (rd_dout[p*WIDTH +: WIDTH] != pdat[DELAY-1][p*WIDTH +: WIDTH]))
          nerr = nerr + 3'd1;
      end else if (rd_vld[p]) begin
        nerr = nerr + 3'd1;
      end
    end
    err_cnt_nxt = sat_add(err_cnt, nerr);
  end

  // check stage: error accumulation
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt <= 16'd0;
      err     <= 1'b0;
    end else begin
      err_cnt <= err_cnt_nxt;
      err     <= err | (err_cnt_nxt != 16'd0);
    end
  end

endmodule

// File: tb/tb_algo_4ror1w_trf_gen.sv
// Randomized bench: transaction-level model of the fill/verify sequence plus a latency-DELAY responder.
module tb_algo_4ror1w_trf_gen;
  localparam int WIDTH   = 8;
  localparam int BITADDR = 4;
  localparam int NUMADDR = 16;
  localparam int DELAY   = 2;
  localparam int REFFREQ = 6;
  localparam logic [WIDTH-1:0] SEED = 8'h00;
  localparam int NGRP  = (NUMADDR + 3) / 4;
  localparam int TOTAL = NUMADDR + NGRP;

  logic                 clk, rst, ready, start;
  logic                 write, refr, busy, done, err;
  logic [BITADDR-1:0]   wr_adr;
  logic [WIDTH-1:0]     din;
  logic [3:0]           read, rd_vld, rd_serr, rd_derr;
  logic [4*BITADDR-1:0] rd_adr;
  logic [4*WIDTH-1:0]   rd_dout;
  logic [15:0]          err_cnt;

  algo_4ror1w_trf_gen #(
    .WIDTH(WIDTH), .BITADDR(BITADDR), .NUMADDR(NUMADDR),
    .DELAY(DELAY), .SEED(SEED), .REFFREQ(REFFREQ)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .start(start),
    .write(write), .wr_adr(wr_adr), .din(din),
    .read(read), .rd_adr(rd_adr), .refr(refr),
    .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_serr(rd_serr), .rd_derr(rd_derr),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: counts of transactions issued, when the last one left, and errors injected.
  bit     m_started, m_all, m_done;
  int     m_wr, m_rd, m_last, m_cyc, m_pend, m_rcnt;
  longint m_err;
  bit     p_rst, p_refr;
  int     p_kind, p_addr;
  bit     q_v [DELAY];
  int     q_b [DELAY];
  int     fault_pct;

  task automatic model_clear();
    m_started = 0; m_all = 0; m_done = 0;
    m_wr = 0; m_rd = 0; m_last = 0; m_err = 0; m_rcnt = 0;
    for (int i = 0; i < DELAY; i++) begin
      q_v[i] = 0;
      q_b[i] = 0;
    end
  endtask

  task automatic step(input bit r, input bit s, input int rdy_pct, input logic [3:0] spur);
    bit exp_w, exp_r, rdy, refr_now, resp_v;
    int resp_b, mode;
    logic [3:0] v, de, se;
    logic [4*WIDTH-1:0] dd;
    logic [WIDTH-1:0] d;
    longint sat;
    @(negedge clk);
    m_cyc++;
    if (!p_rst) model_clear();
    else m_err += m_pend;
    m_pend = 0;
    exp_w  = p_rst && (p_kind == 1);
    exp_r  = p_rst && (p_kind == 2);
    m_done = m_all && (m_cyc >= m_last + DELAY);
    sat    = (m_err > 65535) ? 65535 : m_err;

    check("write", write, exp_w);
    check("read", read, {4{exp_r}});
    if (exp_w) begin
      check("wr_adr", wr_adr, 64'(p_addr));
      check("din", din, 64'(p_addr) ^ 64'(SEED));
    end
    if (exp_r)
      for (int p = 0; p < 4; p++)
        check("rd_adr", rd_adr[p*BITADDR +: BITADDR], 64'((p_addr + p) % NUMADDR));
    if (!p_rst) begin
      check("wr_adr_rst", wr_adr, 0);
      check("din_rst", din, 0);
      check("rd_adr_rst", rd_adr, 0);
    end
    check("refr", refr, p_rst && p_refr);
    check("busy", busy, m_started && !m_done);
    check("done", done, m_done);
    check("err_cnt", err_cnt, 64'(sat));
    check("err", err, m_err != 0);

    // responder: return what was read DELAY cycles ago, occasionally damaged
    resp_v = q_v[0];
    resp_b = q_b[0];
    for (int i = 0; i < DELAY - 1; i++) begin
      q_v[i] = q_v[i+1];
      q_b[i] = q_b[i+1];
    end
    q_v[DELAY-1] = exp_r;
    q_b[DELAY-1] = p_addr;
    v = 4'b0; de = 4'b0; se = 4'($urandom_range(15)); dd = '0;
    for (int p = 0; p < 4; p++) begin
      d = WIDTH'($urandom_range(255));
      if (resp_v) begin
        d = WIDTH'((resp_b + p) % NUMADDR) ^ SEED;
        v[p] = 1'b1;
        mode = (fault_pct > 0 && $urandom_range(99) < fault_pct) ? $urandom_range(1, 4) : 0;
        case (mode)
          1: begin d = d ^ WIDTH'(1 << $urandom_range(WIDTH - 1)); m_pend++; end
          2: begin v[p] = 1'b0; m_pend++; end
          3: begin de[p] = 1'b1; m_pend++; end
          default: ;
        endcase
      end else if (spur[p]) begin
        v[p] = 1'b1;
        m_pend++;
      end
      dd[p*WIDTH +: WIDTH] = d;
    end
    rd_vld = v; rd_dout = dd; rd_derr = de; rd_serr = se;

    rdy = ($urandom_range(99) < rdy_pct);
    rst = r; start = s; ready = rdy;

    p_rst = r; p_kind = 0; p_refr = 0;
    if (r) begin
      refr_now = 0;
`ifdef ALGO_4ROR1W_TRF_REFR_EN
      if (rdy) begin
        m_rcnt++;
        if (m_rcnt == REFFREQ) begin
          refr_now = 1;
          m_rcnt = 0;
        end
      end
`endif
      p_refr = refr_now;
      if (m_started && !m_all && rdy && !refr_now) begin
        if (m_wr < NUMADDR) begin
          p_kind = 1; p_addr = m_wr; m_wr++;
        end else begin
          p_kind = 2; p_addr = 4 * m_rd; m_rd++;
        end
        if (m_wr + m_rd == TOTAL) begin
          m_all = 1;
          m_last = m_cyc + 1;
        end
      end
      if (!m_started && s) m_started = 1;
    end
  endtask

  task automatic run_to_done(input int rdy_pct, input int fpct, input int budget);
    fault_pct = fpct;
    step(1, 1, rdy_pct, 4'b0);
    for (int i = 0; i < budget && !m_done; i++)
      step(1, 1'($urandom_range(1)), rdy_pct, 4'b0);
    check("done_reached", done, 1'b1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ready = 1'b0;
    rd_vld = 4'b0; rd_dout = '0; rd_serr = 4'b0; rd_derr = 4'b0;
    p_rst = 0; p_kind = 0; p_addr = 0; p_refr = 0; m_cyc = 0; m_pend = 0;
    fault_pct = 0;
    model_clear();

    // reset held with start asserted, then idle with no start
    repeat (2) step(0, 1, 100, 4'b0);
    repeat (5) step(1, 0, 100, 4'b0);

    // ideal run, then start pulses in DONE must not restart
    run_to_done(100, 0, 60);
    repeat (4) step(1, 1, 100, 4'b0);

    // random ready, random start noise, damaged responses
    repeat (2) step(0, 0, 100, 4'b0);
    run_to_done(70, 15, 300);
    repeat (3) step(1, 0, 100, 4'b0);

    // ready stall after wr_adr=5
    repeat (2) step(0, 0, 100, 4'b0);
    fault_pct = 0;
    step(1, 1, 100, 4'b0);
    for (int i = 0; i < 40 && !(p_kind == 1 && p_addr == 5); i++) step(1, 0, 100, 4'b0);
    repeat (3) step(1, 0, 0, 4'b0);
    for (int i = 0; i < 60 && !m_done; i++) step(1, 0, 100, 4'b0);
    check("stall_done", done, 1'b1);

    // spurious valid in IDLE, then reset in the middle of READ
    repeat (2) step(0, 0, 100, 4'b0);
    step(1, 0, 100, 4'b0001);
    repeat (2) step(1, 0, 100, 4'b0);
    step(1, 1, 100, 4'b0);
    for (int i = 0; i < 60 && m_rd < 2; i++) step(1, 0, 100, 4'b0);
    step(0, 0, 100, 4'b0);
    repeat (8) step(1, 0, 100, 4'b0);
    check("mid_reset_err_cnt", err_cnt, 0);

    // saturation of the error counter
    repeat (16400) step(1, 0, 100, 4'b1111);
    check("saturated", err_cnt, 16'hFFFF);
    step(0, 0, 100, 4'b0);
    repeat (2) step(1, 0, 100, 4'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/algo_4ror1w_trf_gen.md
ALGO_4ROR1W_TRF_GEN -- requirements
Module: algo_4ror1w_trf_gen

Interface
REQ-001 SHALL have parameters, one per line: WIDTH, 64, data width; BITADDR, 13, address width; NUMADDR, 8192, addressable words; DELAY, 2, fixed read latency in cycles (>=1); SEED, 0, WIDTH-bit data XOR pattern; REFFREQ, 6, refresh period in cycles (>=2).
REQ-002 SHALL have ports, one per line: clk in 1 clock; rst in 1 reset; ready in 1 memory ready; start in 1 run request pulse; write out 1; wr_adr out BITADDR; din out WIDTH; read out 4; rd_adr out 4*BITADDR; refr out 1; rd_vld in 4; rd_dout in 4*WIDTH; rd_serr in 4; rd_derr in 4; busy out 1; done out 1; err out 1; err_cnt out 16.
REQ-003 SHALL use one clock, clk; reset rst SHALL be synchronous and active-low.
REQ-004 SHALL drive all outputs from flops; port p of read/rd_adr/rd_dout/rd_vld SHALL occupy slice p (p=0..3, LSB first).

Function
REQ-005 SHALL implement states IDLE, FILL, READ, DRAIN, DONE.
REQ-006 IDLE: start=1 -> FILL, busy=1, address counter=0; start in any other state SHALL be ignored.
REQ-007 Issue cycle: a cycle in FILL/READ with ready=1 and refr not asserted in that cycle; in non-issue cycles write=0, read=0, and counters hold.
REQ-008 FILL: per issue cycle, write=1, wr_adr=counter, din=zero-extended counter XOR SEED; counter increments; after address NUMADDR-1 -> READ, counter=0.
REQ-009 READ: per issue cycle, read=4'b1111, rd_adr slice p=(counter+p) mod NUMADDR; counter += 4; when counter+4 >= NUMADDR after issue -> DRAIN.
REQ-010 write and read SHALL never be asserted in the same cycle.
REQ-011 Expected-response pipe: DELAY-stage shift register per port holding valid bit and expected data (address XOR SEED), loaded at each issue, shifted every cycle regardless of ready.
REQ-012 At pipe output, per port: expected valid and (rd_vld=0 or rd_dout mismatch or rd_derr=1) -> one error; rd_vld=1 with no expectation -> one error; rd_serr SHALL be ignored.
REQ-013 err_cnt SHALL add the number of erroring ports per cycle (0..4), saturating at 16'hFFFF; err SHALL be sticky once err_cnt is nonzero.
REQ-014 DRAIN SHALL last exactly DELAY cycles, then DONE: busy=0, done=1 held until reset; DONE SHALL NOT restart.
REQ-015 ready deasserted mid-FILL/READ SHALL freeze the counter; in-flight reads SHALL still be checked; resumption SHALL continue at the frozen address.

Reset
REQ-016 rst=0 at a clock edge SHALL force IDLE, counters and pipe to 0, and write, read, refr, busy, done, err, err_cnt, wr_adr, rd_adr, din to 0, including mid-operation; in-flight expectations SHALL be discarded.

Configuration
REQ-017 Macro ALGO_4ROR1W_TRF_REFR_EN defined: free-running refresh counter increments when ready=1, asserts refr for one cycle when it reaches REFFREQ-1 and wraps to 0; that cycle is not an issue cycle.
REQ-018 Macro undefined: refr SHALL be constant 0 and no refresh counter exists; every ready cycle in FILL/READ is an issue cycle.

Verification (NUMADDR=16, BITADDR=4, WIDTH=8, DELAY=2, SEED=8'h00 unless stated)
REQ-019 rst=0 two cycles with start=1 -> all outputs 0, state IDLE; after release no activity until a start pulse.
REQ-020 Macro undefined, ideal responder, ready=1, start pulse -> 16 writes wr_adr 0..15 din 0x00..0x0F, then 4 reads rd_adr {3,2,1,0}..{15,14,13,12}, done=1 two cycles after last read, err_cnt=0.
REQ-021 Same run, responder flips rd_dout port 2 bit 0 on one response -> err_cnt=1, err=1; all four ports corrupted in one cycle -> err_cnt += 4.
REQ-022 ready=0 for 3 cycles after wr_adr=5 -> write=0 for those cycles; next write carries wr_adr=6, din=0x06.
REQ-023 Macro defined, REFFREQ=6 -> refr pulses every 6th ready cycle, write=read=0 in those cycles; FILL needs 19 cycles; err_cnt=0.
REQ-024 rd_vld=4'b0001 in IDLE -> err_cnt=1; rst=0 in mid-READ -> err_cnt=0, busy=0, no error reported for dropped in-flight reads.
